// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
//   Shares one single-write-port / registered-read-port RAM between two
//   requesters (m0, m1). After reset (optionally) and on a clear pulse it
//   walks every address writing INIT_VAL. Otherwise it grants at most one
//   access per cycle, either round-robin or with m0 taking priority.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   clear                 pulse; starts a clear sequence while arbitrating
//   m*_req/we/addr/wdata  requester payload, held until m*_gnt
//   m*_gnt                combinational grant for this cycle
//   m*_rvalid/m*_rdata    read return, one cycle after a granted read
//   ram_we/wdata/waddr    RAM write port
//   ram_raddr, ram_q      RAM read address and registered read data
//   init_done             1 while arbitrating with no clear in progress
module ram_access_arbiter #(
    parameter int              AW             = 6,
    parameter int              DW             = 8,
    parameter logic [DW-1:0]   INIT_VAL       = {DW{1'b0}},
    parameter int              CLEAR_ON_RESET = 1,
    parameter int              FIXED_PRIO     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    output logic [AW-1:0] ram_waddr,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_q,
    output logic          init_done
);

    localparam logic [0:0]    ST_INIT   = 1'b0;
    localparam logic [0:0]    ST_ARB    = 1'b1;
    localparam logic [0:0]    ST_RESET  = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_ARB;
    localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

    logic [0:0]    state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          last_gnt_reg, last_gnt_next;   // 0 = m0, 1 = m1
    logic          init_done_reg, init_done_next;
    logic          m0_rvalid_reg, m1_rvalid_reg;
    logic [AW-1:0] raddr_reg;

    logic          arb_en;
    logic          pick_m1;
    logic          gnt0, gnt1, any_gnt;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Grants need init_done as well as the ARB state so that, with the clear
    // skipped at reset, the first grant lands on the first edge after release.
    assign arb_en  = (state_reg == ST_ARB) && init_done_reg;
    // Tie-break: round-robin favours whoever did not win last time.
    assign pick_m1 = (FIXED_PRIO != 0) ? 1'b0 : ~last_gnt_reg;
    assign gnt0    = arb_en & m0_req & (~m1_req | ~pick_m1);
    assign gnt1    = arb_en & m1_req & (~m0_req | pick_m1);
    assign any_gnt = gnt0 | gnt1;

    assign win_we    = gnt1 ? m1_we    : m0_we;
    assign win_addr  = gnt1 ? m1_addr  : m0_addr;
    assign win_wdata = gnt1 ? m1_wdata : m0_wdata;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = win_addr;
        ram_wdata = win_wdata;
        if (state_reg == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = cnt_reg;
            ram_wdata = INIT_VAL;
        end else begin
            ram_we = any_gnt & win_we;
        end
    end

    // Read address holds its last driven value when no read is granted.
    assign ram_raddr = (any_gnt && !win_we) ? win_addr : raddr_reg;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        last_gnt_next  = last_gnt_reg;
        if (state_reg == ST_INIT) begin
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_ADDR) begin
                state_next = ST_ARB;
                cnt_next   = '0;
            end
        end else begin
            if (any_gnt) begin
                last_gnt_next = gnt1;
            end
            if (clear) begin
                state_next = ST_INIT;
                cnt_next   = '0;
            end
        end
        init_done_next = (state_next == ST_ARB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_RESET;
            cnt_reg       <= '0;
            last_gnt_reg  <= 1'b1;
            init_done_reg <= 1'b0;
            m0_rvalid_reg <= 1'b0;
            m1_rvalid_reg <= 1'b0;
            raddr_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            last_gnt_reg  <= last_gnt_next;
            init_done_reg <= init_done_next;
            m0_rvalid_reg <= gnt0 & ~m0_we;
            m1_rvalid_reg <= gnt1 & ~m1_we;
            raddr_reg     <= ram_raddr;
        end
    end

    assign m0_gnt    = gnt0;
    assign m1_gnt    = gnt1;
    assign m0_rvalid = m0_rvalid_reg;
    assign m1_rvalid = m1_rvalid_reg;
    assign m0_rdata  = ram_q;
    assign m1_rdata  = ram_q;
    assign init_done = init_done_reg;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter. Two instances share the stimulus:
//   a: default parameters (clear on reset, round-robin)
//   b: CLEAR_ON_RESET=0, FIXED_PRIO=1
// Each instance drives its own behavioural 64x8 RAM with registered read.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [5:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;

    logic       a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [7:0] a_m0_rdata, a_m1_rdata;
    logic       a_ram_we, a_init_done;
    logic [7:0] a_ram_wdata, a_ram_q;
    logic [5:0] a_ram_waddr, a_ram_raddr;

    logic       b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [7:0] b_m0_rdata, b_m1_rdata;
    logic       b_ram_we, b_init_done;
    logic [7:0] b_ram_wdata, b_ram_q;
    logic [5:0] b_ram_waddr, b_ram_raddr;

    logic [7:0] a_mem [64];
    logic [7:0] b_mem [64];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ram_access_arbiter dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .ram_we(a_ram_we), .ram_wdata(a_ram_wdata), .ram_waddr(a_ram_waddr),
        .ram_raddr(a_ram_raddr), .ram_q(a_ram_q), .init_done(a_init_done)
    );

    ram_access_arbiter #(.CLEAR_ON_RESET(0), .FIXED_PRIO(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_we(b_ram_we), .ram_wdata(b_ram_wdata), .ram_waddr(b_ram_waddr),
        .ram_raddr(b_ram_raddr), .ram_q(b_ram_q), .init_done(b_init_done)
    );

    // Behavioural RAMs: write port plus 1-cycle registered read.
    always @(posedge clk) begin
        if (a_ram_we) a_mem[a_ram_waddr] <= a_ram_wdata;
        a_ram_q <= a_mem[a_ram_raddr];
        if (b_ram_we) b_mem[b_ram_waddr] <= b_ram_wdata;
        b_ram_q <= b_mem[b_ram_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 64; k++) begin
            a_mem[k] = 8'hFF;
            b_mem[k] = 8'hFF;
        end
        rst_n = 1'b0; clear = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_init_done", a_init_done, 0);
        check("rst_a_m0_rvalid", a_m0_rvalid, 0);
        check("rst_b_init_done", b_init_done, 0);

        // Reset release with m0 already requesting a read of addr 5.
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd5;
        #1;
        for (int i = 0; i < 64; i++) begin
            check("clr_we", a_ram_we, 1);
            check("clr_addr", a_ram_waddr, i);
            check("clr_data", a_ram_wdata, 0);
            check("clr_m0_gnt", a_m0_gnt, 0);
            check("clr_done", a_init_done, 0);
            if (i == 0) begin
                check("b_first_done", b_init_done, 0);
                check("b_first_gnt", b_m0_gnt, 0);
            end else begin
                check("b_arb_done", b_init_done, 1);
                check("b_arb_gnt", b_m0_gnt, 1);
            end
            check("b_no_we", b_ram_we, 0);
            cyc();
        end
        check("post_clr_done", a_init_done, 1);
        check("post_clr_gnt", a_m0_gnt, 1);
        check("post_clr_raddr", a_ram_raddr, 5);
        check("post_clr_we", a_ram_we, 0);
        cyc();
        m0_req = 1'b0;
        #1;
        check("rd5_rvalid", a_m0_rvalid, 1);
        check("rd5_rdata", a_m0_rdata, 8'h00);
        check("rd5_m1_rvalid", a_m1_rvalid, 0);

        // Write A5 to 12 by m0, then m1 reads 12.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd12; m0_wdata = 8'hA5;
        #1;
        check("wr12_gnt", a_m0_gnt, 1);
        check("wr12_we", a_ram_we, 1);
        check("wr12_addr", a_ram_waddr, 12);
        check("wr12_data", a_ram_wdata, 8'hA5);
        cyc();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd12;
        #1;
        check("rd12_gnt", a_m1_gnt, 1);
        check("rd12_m0_rvalid", a_m0_rvalid, 0);
        cyc();
        m1_req = 1'b0;
        #1;
        check("rd12_rvalid", a_m1_rvalid, 1);
        check("rd12_rdata", a_m1_rdata, 8'hA5);
        check("rd12_m0_rvalid2", a_m0_rvalid, 0);

        // Contention: both read for 6 cycles.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd1;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd2;
        #1;
        for (int i = 0; i < 6; i++) begin
            check("rr_m0_gnt", a_m0_gnt, (i % 2 == 0) ? 1 : 0);
            check("rr_m1_gnt", a_m1_gnt, (i % 2 == 1) ? 1 : 0);
            check("fp_m0_gnt", b_m0_gnt, 1);
            check("fp_m1_gnt", b_m1_gnt, 0);
            if (i > 0) check("rr_m0_rvalid", a_m0_rvalid, (i % 2 == 1) ? 1 : 0);
            cyc();
        end
        m0_req = 1'b0; m1_req = 1'b0;

        // Write 3C to addr 3, then m1 reads it in the same cycle clear is pulsed.
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd3; m0_wdata = 8'h3C;
        #1;
        check("wr3_gnt", a_m0_gnt, 1);
        cyc();
        m0_req = 1'b0; m0_we = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd3;
        clear = 1'b1;
        #1;
        check("clr_rd3_gnt", a_m1_gnt, 1);
        check("clr_rd3_raddr", a_ram_raddr, 3);
        cyc();
        clear = 1'b0; m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd3;
        #1;
        check("clr_rd3_rvalid", a_m1_rvalid, 1);
        check("clr_rd3_rdata", a_m1_rdata, 8'h3C);
        for (int i = 0; i < 64; i++) begin
            check("clr2_done", a_init_done, 0);
            check("clr2_gnt", a_m0_gnt, 0);
            check("clr2_addr", a_ram_waddr, i);
            clear = (i == 10);
            cyc();
        end
        clear = 1'b0;
        check("clr2_end_done", a_init_done, 1);
        check("clr2_end_gnt", a_m0_gnt, 1);
        cyc();
        m0_req = 1'b0;
        #1;
        check("rd3_rvalid", a_m0_rvalid, 1);
        check("rd3_rdata", a_m0_rdata, 8'h00);

        // In-flight rvalid squashed by async reset.
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd12;
        #1;
        check("sq_gnt", a_m1_gnt, 1);
        cyc();
        m1_req = 1'b0;
        #1;
        check("sq_rvalid_before", a_m1_rvalid, 1);
        rst_n = 1'b0;
        #1;
        check("sq_rvalid_after", a_m1_rvalid, 0);
        check("sq_done", a_init_done, 0);
        check("sq_b_done", b_init_done, 0);
        cyc();
        rst_n = 1'b1;
        #1;

        // Reset again mid-clear at address 30.
        for (int i = 0; i <= 30; i++) begin
            check("mid_addr", a_ram_waddr, i);
            if (i < 30) cyc();
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", a_init_done, 0);
        check("mid_rst_addr", a_ram_waddr, 0);
        check("mid_rst_rvalid", a_m0_rvalid, 0);
        cyc();
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 64; i++) begin
            check("re_clr_we", a_ram_we, 1);
            check("re_clr_addr", a_ram_waddr, i);
            check("re_clr_done", a_init_done, 0);
            cyc();
        end
        check("re_clr_end_done", a_init_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
